// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extracts/extends RV32I/RV64I immediates behind a
// valid/ready output register plus one skid entry. Define IMM_GEN_PC_TARGET_EN to add PC+imm.
module imm_gen_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic              i_CLK,
    input  logic              i_RST_n,
    input  logic              i_VALID,
    output logic              o_READY,
    input  logic [INST_W-1:0] i_INST_D,
    input  logic [2:0]        i_Inst_Type,
    input  logic              i_FLUSH,
    output logic              o_VALID,
    input  logic              i_READY_OUT,
    output logic [XLEN-1:0]   o_ImmEXT_D,
`ifdef IMM_GEN_PC_TARGET_EN
    input  logic [XLEN-1:0]   i_PC,
    output logic [XLEN-1:0]   o_TARGET,
`endif
    output logic              o_ILLEGAL
);

    typedef enum logic [2:0] {
        TypeI     = 3'b000,
        TypeS     = 3'b001,
        TypeB     = 3'b010,
        TypeJ     = 3'b011,
        TypeU     = 3'b100,
        TypeZimm  = 3'b101,
        TypeShamt = 3'b110,
        TypeRsvd  = 3'b111
    } inst_type_e;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_new;
    logic            ill_new;
    logic            unused_opcode;

    assign unused_opcode = ^i_INST_D[6:0];

    // Zero-extended formats leave bit 31 clear, so one sign extension from bit 31 serves all.
    always_comb begin
        imm32   = '0;
        ill_new = 1'b0;
        case (inst_type_e'(i_Inst_Type))
            TypeI: imm32 = {{20{i_INST_D[31]}}, i_INST_D[31:20]};
            TypeS: imm32 = {{20{i_INST_D[31]}}, i_INST_D[31:25], i_INST_D[11:7]};
            TypeB: imm32 = {{19{i_INST_D[31]}}, i_INST_D[31], i_INST_D[7], i_INST_D[30:25],
                            i_INST_D[11:8], 1'b0};
            TypeJ: imm32 = {{11{i_INST_D[31]}}, i_INST_D[31], i_INST_D[19:12], i_INST_D[20],
                            i_INST_D[30:21], 1'b0};
            TypeU: imm32 = {i_INST_D[31:12], 12'b0};
            TypeZimm: imm32 = {27'b0, i_INST_D[19:15]};
            TypeShamt: begin
                if (XLEN == 64) imm32 = {26'b0, i_INST_D[25:20]};
                else            imm32 = {27'b0, i_INST_D[24:20]};
            end
            default: ill_new = 1'b1;
        endcase
    end

    if (XLEN > 32) begin : g_ext
        assign imm_new = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_noext
        assign imm_new = imm32;
    end

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic            out_ill_q, out_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            skid_ill_q, skid_ill_d;
    logic            ready_q, ready_d;
    logic            push, pop;

`ifdef IMM_GEN_PC_TARGET_EN
    logic [XLEN-1:0] tgt_new;
    logic [XLEN-1:0] out_tgt_q, out_tgt_d;
    logic [XLEN-1:0] skid_tgt_q, skid_tgt_d;

    assign tgt_new = i_PC + imm_new;
`endif

    assign push = i_VALID && ready_q;
    assign pop  = out_valid_q && i_READY_OUT;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;
`ifdef IMM_GEN_PC_TARGET_EN
        out_tgt_d    = out_tgt_q;
        skid_tgt_d   = skid_tgt_q;
`endif
        if (i_FLUSH) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || pop) begin
            // Skid full implies o_READY low, so push and skid drain never coincide.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
`ifdef IMM_GEN_PC_TARGET_EN
                out_tgt_d    = skid_tgt_q;
`endif
            end else if (push) begin
                out_valid_d = 1'b1;
                out_imm_d   = imm_new;
                out_ill_d   = ill_new;
`ifdef IMM_GEN_PC_TARGET_EN
                out_tgt_d   = tgt_new;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = imm_new;
            skid_ill_d   = ill_new;
`ifdef IMM_GEN_PC_TARGET_EN
            skid_tgt_d   = tgt_new;
`endif
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
            ready_q      <= 1'b0;
`ifdef IMM_GEN_PC_TARGET_EN
            out_tgt_q    <= '0;
            skid_tgt_q   <= '0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
            ready_q      <= ready_d;
`ifdef IMM_GEN_PC_TARGET_EN
            out_tgt_q    <= out_tgt_d;
            skid_tgt_q   <= skid_tgt_d;
`endif
        end
    end

    assign o_VALID    = out_valid_q;
    assign o_ImmEXT_D = out_imm_q;
    assign o_ILLEGAL  = out_ill_q;
    assign o_READY    = ready_q;
`ifdef IMM_GEN_PC_TARGET_EN
    assign o_TARGET   = out_tgt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; a queue model
// of the two-entry buffer predicts every output.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready_out, flush;
    logic [31:0] inst;
    logic [2:0]  itype;
    logic [63:0] pc;

    logic        rdy32, rdy64, v32, v64, ill32, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
`ifdef IMM_GEN_PC_TARGET_EN
    logic [31:0] tgt32;
    logic [63:0] tgt64;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .INST_W(32)) dut32 (
        .i_CLK(clk), .i_RST_n(rst_n), .i_VALID(valid), .o_READY(rdy32),
        .i_INST_D(inst), .i_Inst_Type(itype), .i_FLUSH(flush), .o_VALID(v32),
        .i_READY_OUT(ready_out), .o_ImmEXT_D(imm32),
`ifdef IMM_GEN_PC_TARGET_EN
        .i_PC(pc[31:0]), .o_TARGET(tgt32),
`endif
        .o_ILLEGAL(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .INST_W(32)) dut64 (
        .i_CLK(clk), .i_RST_n(rst_n), .i_VALID(valid), .o_READY(rdy64),
        .i_INST_D(inst), .i_Inst_Type(itype), .i_FLUSH(flush), .o_VALID(v64),
        .i_READY_OUT(ready_out), .o_ImmEXT_D(imm64),
`ifdef IMM_GEN_PC_TARGET_EN
        .i_PC(pc), .o_TARGET(tgt64),
`endif
        .o_ILLEGAL(ill64)
    );

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic        ill;
        logic [31:0] t32;
        logic [63:0] t64;
    } item_t;

    item_t q[$];
    logic  ready_m;

    // Immediate value as a signed integer, then truncated to the datapath width.
    function automatic logic [63:0] ref_imm(input logic [31:0] in, input logic [2:0] t,
                                           input int xlen);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [31:0] u32;
        longint v;
        case (t)
            3'd0: begin i12 = in[31:20]; v = i12; end
            3'd1: begin i12 = {in[31:25], in[11:7]}; v = i12; end
            3'd2: begin b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0}; v = b13; end
            3'd3: begin j21 = {in[31], in[19:12], in[20], in[30:21], 1'b0}; v = j21; end
            3'd4: begin u32 = {in[31:12], 12'h000}; v = u32; end
            3'd5: v = longint'(in[19:15]);
            3'd6: v = (xlen == 64) ? longint'(in[25:20]) : longint'(in[24:20]);
            default: v = 0;
        endcase
        return (xlen == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    task automatic tick();
        item_t it;
        logic  push, pop;
        pop  = (q.size() > 0) && ready_out;
        push = valid && ready_m;
        it.i64 = ref_imm(inst, itype, 64);
        it.i32 = ref_imm(inst, itype, 32);
        it.ill = (itype == 3'd7);
        it.t32 = pc[31:0] + it.i32;
        it.t64 = pc + it.i64;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pop) q.delete(0);
            if (push) q.push_back(it);
        end
        ready_m = (q.size() < 2);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; flush = 1'b0; inst = '0; itype = '0; pc = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ready_out = 1'b1;
        rst_n = 1'b0;
        q.delete(); ready_m = 1'b0;
        #12;
        nvec++; if (v32 !== 1'b0 || v64 !== 1'b0) begin
            nerr++; $display("FAIL reset_valid: got %b/%b want 0/0", v32, v64); end
        nvec++; if (imm32 !== 32'h0 || imm64 !== 64'h0) begin
            nerr++; $display("FAIL reset_imm: got %h/%h want 0", imm32, imm64); end
        nvec++; if (ill32 !== 1'b0 || ill64 !== 1'b0) begin
            nerr++; $display("FAIL reset_ill: got %b/%b want 0", ill32, ill64); end
        rst_n = 1'b1;
        tick();
        nvec++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            nerr++; $display("FAIL reset_ready: got %b/%b want 1/1", rdy32, rdy64); end
    endtask

    task automatic test_itype();
        ready_out = 1'b1;
        valid = 1'b1; inst = 32'hFFF00093; itype = 3'd0;
        tick();
        valid = 1'b0;
        nvec++; if (v32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || ill32 !== 1'b0) begin
            nerr++; $display("FAIL itype32: got v=%b imm=%h ill=%b want 1 ffffffff 0",
                             v32, imm32, ill32); end
        nvec++; if (v64 !== 1'b1 || imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
            nerr++; $display("FAIL itype64: got v=%b imm=%h want 1 ffffffffffffffff", v64, imm64);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ready_out = 1'b1;
        valid = 1'b1; inst = 32'hFE000EE3; itype = 3'd2;
        tick();
        nvec++; if (v32 !== 1'b1 || imm32 !== 32'hFFFFFFFC || rdy32 !== 1'b1) begin
            nerr++; $display("FAIL b2b_btype: got v=%b imm=%h rdy=%b want 1 fffffffc 1",
                             v32, imm32, rdy32); end
        inst = 32'h12345037; itype = 3'd4;
        tick();
        valid = 1'b0;
        nvec++; if (v32 !== 1'b1 || imm32 !== 32'h12345000 || imm64 !== 64'h12345000) begin
            nerr++; $display("FAIL b2b_utype: got v=%b imm=%h/%h want 1 12345000", v32, imm32, imm64);
        end
        tick();
        nvec++; if (v32 !== 1'b0 || v64 !== 1'b0) begin
            nerr++; $display("FAIL b2b_drain: got v=%b/%b want 0/0", v32, v64); end
    endtask

    task automatic test_backpressure();
        ready_out = 1'b0;
        valid = 1'b1; inst = 32'h00500093; itype = 3'd0;
        tick();
        inst = 32'h00112223; itype = 3'd1;
        tick();
        valid = 1'b0; inst = '0;
        nvec++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0 || imm32 !== 32'd5 || v32 !== 1'b1) begin
            nerr++; $display("FAIL bp_full: got rdy=%b/%b imm=%0d v=%b want 0/0 5 1",
                             rdy32, rdy64, imm32, v32); end
        tick();
        nvec++; if (imm32 !== 32'd5 || imm64 !== 64'd5 || ill32 !== 1'b0) begin
            nerr++; $display("FAIL bp_hold: got imm=%0d/%0d ill=%b want 5 0", imm32, imm64, ill32);
        end
        ready_out = 1'b1;
        tick();
        nvec++; if (v32 !== 1'b1 || imm32 !== 32'd4 || rdy32 !== 1'b1) begin
            nerr++; $display("FAIL bp_second: got v=%b imm=%0d rdy=%b want 1 4 1", v32, imm32, rdy32);
        end
        tick();
        nvec++; if (v32 !== 1'b0 || v64 !== 1'b0) begin
            nerr++; $display("FAIL bp_empty: got v=%b/%b want 0/0", v32, v64); end
    endtask

    task automatic test_xlen64();
        ready_out = 1'b1;
        valid = 1'b1; inst = 32'h0080006F; itype = 3'd3;
        tick();
        nvec++; if (imm64 !== 64'd8 || imm32 !== 32'd8) begin
            nerr++; $display("FAIL jtype: got %h/%h want 8", imm64, imm32); end
        inst = 32'h03F01013; itype = 3'd6;
        tick();
        nvec++; if (imm64 !== 64'd63 || imm32 !== 32'd31) begin
            nerr++; $display("FAIL shamt: got %0d/%0d want 63/31", imm64, imm32); end
        inst = 32'h80000037; itype = 3'd4;
        tick();
        nvec++; if (imm64 !== 64'hFFFFFFFF80000000 || imm32 !== 32'h80000000) begin
            nerr++; $display("FAIL utype64: got %h/%h want ffffffff80000000/80000000",
                             imm64, imm32); end
        inst = 32'hFFFF8073; itype = 3'd5;
        tick();
        valid = 1'b0;
        nvec++; if (imm64 !== 64'd31 || imm32 !== 32'd31) begin
            nerr++; $display("FAIL zimm: got %0d/%0d want 31", imm64, imm32); end
        tick();
    endtask

    task automatic test_flush();
        ready_out = 1'b0;
        valid = 1'b1; inst = 32'h00700093; itype = 3'd0;
        tick();
        inst = 32'h00800093;
        tick();
        flush = 1'b1; inst = 32'h00900093;
        tick();
        flush = 1'b0; valid = 1'b0;
        nvec++; if (v32 !== 1'b0 || v64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            nerr++; $display("FAIL flush_full: got v=%b/%b rdy=%b/%b want 0/0 1/1",
                             v32, v64, rdy32, rdy64); end
        ready_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++; if (v32 !== 1'b0 || v64 !== 1'b0) begin
                nerr++; $display("FAIL flush_ghost: got v=%b/%b want 0/0", v32, v64); end
        end
        ready_out = 1'b0;
        valid = 1'b1; inst = 32'h00A00093;
        tick();
        flush = 1'b1; inst = 32'h00B00093;
        tick();
        flush = 1'b0; valid = 1'b0; ready_out = 1'b1;
        tick();
        nvec++; if (v32 !== 1'b0 || v64 !== 1'b0) begin
            nerr++; $display("FAIL flush_discard: got v=%b/%b want 0/0", v32, v64); end
        valid = 1'b1; inst = 32'hFFFFFFFF; itype = 3'd7;
        tick();
        valid = 1'b0;
        nvec++; if (v32 !== 1'b1 || imm32 !== 32'h0 || ill32 !== 1'b1 ||
                    imm64 !== 64'h0 || ill64 !== 1'b1) begin
            nerr++; $display("FAIL illegal: got v=%b imm=%h/%h ill=%b/%b want 1 0 1",
                             v32, imm32, imm64, ill32, ill64); end
        tick();
    endtask

    task automatic test_target();
`ifdef IMM_GEN_PC_TARGET_EN
        ready_out = 1'b1;
        valid = 1'b1; inst = 32'hFE000EE3; itype = 3'd2; pc = 64'h1000;
        tick();
        valid = 1'b0;
        nvec++; if (tgt32 !== 32'h00000FFC || tgt64 !== 64'h0000000000000FFC) begin
            nerr++; $display("FAIL target: got %h/%h want ffc", tgt32, tgt64); end
        tick();
        pc = '0;
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            valid     = ($urandom_range(0, 3) != 0);
            ready_out = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            inst      = $urandom;
            itype     = 3'($urandom_range(0, 7));
            pc        = {$urandom, $urandom};
            tick();
            nvec++; if (v32 !== (q.size() > 0) || v64 !== (q.size() > 0)) begin
                nerr++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b", n, v32, v64,
                                 q.size() > 0); end
            nvec++; if (rdy32 !== ready_m || rdy64 !== ready_m) begin
                nerr++; $display("FAIL rnd_ready[%0d]: got %b/%b want %b", n, rdy32, rdy64, ready_m);
            end
            if (q.size() > 0) begin
                nvec++; if (imm32 !== q[0].i32 || imm64 !== q[0].i64) begin
                    nerr++; $display("FAIL rnd_imm[%0d]: got %h/%h want %h/%h", n, imm32, imm64,
                                     q[0].i32, q[0].i64); end
                nvec++; if (ill32 !== q[0].ill || ill64 !== q[0].ill) begin
                    nerr++; $display("FAIL rnd_ill[%0d]: got %b/%b want %b", n, ill32, ill64,
                                     q[0].ill); end
`ifdef IMM_GEN_PC_TARGET_EN
                nvec++; if (tgt32 !== q[0].t32 || tgt64 !== q[0].t64) begin
                    nerr++; $display("FAIL rnd_tgt[%0d]: got %h/%h want %h/%h", n, tgt32, tgt64,
                                     q[0].t32, q[0].t64); end
`endif
            end
        end
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        ready_out = 1'b0;
        valid = 1'b1; inst = 32'h00500093; itype = 3'd0;
        tick();
        tick();
        valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        nvec++; if (v32 !== 1'b0 || v64 !== 1'b0 || imm32 !== 32'h0 || imm64 !== 64'h0) begin
            nerr++; $display("FAIL async_reset: got v=%b/%b imm=%h/%h want 0 0",
                             v32, v64, imm32, imm64); end
        q.delete(); ready_m = 1'b0;
        #2;
        rst_n = 1'b1;
        ready_out = 1'b1;
        tick();
        nvec++; if (v32 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            nerr++; $display("FAIL post_reset: got v=%b rdy=%b/%b want 0 1/1", v32, rdy32, rdy64);
        end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_backpressure();
        test_xlen64();
        test_flush();
        test_target();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
